regfile_wb: RTL and testbench

- Integer register file; the consuming end of the writeback port driven by the LSU/WB pipeline register.
- Accepts one write per cycle (rd_we/rd_addr/rd_data) from writeback.
- Serves two combinational read ports to the decode stage, with write-first bypass.
- Exposes a debug access port with a req/ack handshake that shares the single write port with writeback.

---
 rtl/regfile_wb.sv | 119 +++++++++++
 tb/tb_regfile_wb.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Integer register file: writeback write port, two write-first bypassed read
// ports, and a debug req/ack port that borrows the write port when it is idle.
module regfile_wb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_we_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_ack_o,
  output logic [DATA_W-1:0] dbg_rdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [DATA_W-1:0] r_regs [1:NUM_REGS-1];
  logic [DATA_W-1:0] r_dbg_rdata;

  logic              w_wb_busy;
  logic              w_dbg_rd;
  logic              w_dbg_wr;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_rs1_data;
  logic [DATA_W-1:0] w_rs2_data;
  logic [DATA_W-1:0] w_dbg_data;

  // Index 0 and out-of-range indices never match a stored entry, so they read 0
  // and are never bypassed.
  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
    f_read = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (a == ADDR_W'(k)) begin
        f_read = (rd_we_i && (rd_addr_i == a)) ? rd_data_i : r_regs[k];
      end
    end
  endfunction

  always_comb begin
    w_rs1_data = f_read(rs1_addr_i);
    w_rs2_data = f_read(rs2_addr_i);
    w_dbg_data = f_read(dbg_addr_i);
  end

  assign rs1_data_o = w_rs1_data;
  assign rs2_data_o = w_rs2_data;

  // A writeback to x0 does not occupy the port, so a debug write may proceed.
  assign w_wb_busy = rd_we_i && (rd_addr_i != '0);
  assign w_wr_en   = w_wb_busy || w_dbg_wr;
  assign w_wr_addr = w_wb_busy ? rd_addr_i : dbg_addr_i;
  assign w_wr_data = w_wb_busy ? rd_data_i : dbg_wdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else if (w_wr_en) begin
      for (int k = 1; k < NUM_REGS; k++) begin
        if (w_wr_addr == ADDR_W'(k)) begin
          r_regs[k] <= w_wr_data;
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_dbg_rd     = 1'b0;
    w_dbg_wr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dbg_req_i) begin
          if (!dbg_we_i) begin
            w_dbg_rd     = 1'b1;
            w_state_next = S_ACK;
          end else if (!w_wb_busy) begin
            w_dbg_wr     = 1'b1;
            w_state_next = S_ACK;
          end
        end
      end
      S_ACK:   w_state_next = S_WAIT;
      S_WAIT:  if (!dbg_req_i) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dbg_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_dbg_rd) begin
        r_dbg_rdata <= w_dbg_data;
      end
    end
  end

  assign dbg_ack_o   = (r_state == S_ACK);
  assign dbg_rdata_o = r_dbg_rdata;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench for regfile_wb: reads compared against a plain array model,
// debug acks popped from an expectation queue by an independent monitor.
module tb_regfile_wb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_we_i;
  logic [AW-1:0] rd_addr_i;
  logic [DW-1:0] rd_data_i;
  logic [AW-1:0] rs1_addr_i;
  logic [DW-1:0] rs1_data_o;
  logic [AW-1:0] rs2_addr_i;
  logic [DW-1:0] rs2_data_o;
  logic          dbg_req_i;
  logic          dbg_we_i;
  logic [AW-1:0] dbg_addr_i;
  logic [DW-1:0] dbg_wdata_i;
  logic          dbg_ack_o;
  logic [DW-1:0] dbg_rdata_o;

  regfile_wb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .rs1_addr_i(rs1_addr_i), .rs1_data_o(rs1_data_o),
    .rs2_addr_i(rs2_addr_i), .rs2_data_o(rs2_data_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_ack_o(dbg_ack_o), .dbg_rdata_o(dbg_rdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        is_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nfail = 0;
  int          ncyc = 0;
  logic [31:0] mregs [NR];
  int          dbg_st = 0;  // 0: req low, 1: req waiting to be served, 2: served, req still high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic logic [31:0] mread(input logic [AW-1:0] a, input logic we,
                                        input logic [AW-1:0] wa, input logic [31:0] wd);
    if (a == 0 || int'(a) >= NR) return 32'h0;
    if (we && wa == a) return wd;
    return mregs[a];
  endfunction

  // Monitor: every ack must match the oldest queued expectation, on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (dbg_ack_o === 1'b1) begin
      if (q.size() == 0) begin
        nvec++; nfail++;
        $display("FAIL dbg_ack_spurious: got ack=1, want ack=0 (cycle %0d)", ncyc);
      end else begin
        e = q.pop_front();
        chk("dbg_ack_cycle", ncyc, e.due);
        if (e.is_rd) chk("dbg_rdata", dbg_rdata_o, e.rdata);
      end
    end else if (q.size() != 0 && q[0].due <= ncyc) begin
      e = q.pop_front();
      nvec++; nfail++;
      $display("FAIL dbg_ack_missing: got ack=0, want ack=1 (cycle %0d)", ncyc);
    end
  end

  // One clock of stimulus; entered at/after a negedge, returns at the next negedge.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic req, input logic dwe, input logic [AW-1:0] da,
                       input logic [31:0] dwd,
                       input bit xchk = 0, input logic [31:0] x1 = 0, input logic [31:0] x2 = 0);
    logic busy;
    exp_t e;
    rd_we_i = we; rd_addr_i = wa; rd_data_i = wd;
    rs1_addr_i = a1; rs2_addr_i = a2;
    dbg_req_i = req; dbg_we_i = dwe; dbg_addr_i = da; dbg_wdata_i = dwd;
    if (!req) dbg_st = 0;
    else if (dbg_st == 0) dbg_st = 1;
    #1;
    chk("rs1_data", rs1_data_o, mread(a1, we, wa, wd));
    chk("rs2_data", rs2_data_o, mread(a2, we, wa, wd));
    if (xchk) begin
      chk("rs1_const", rs1_data_o, x1);
      chk("rs2_const", rs2_data_o, x2);
    end
    @(posedge clk);
    if (rst_n) begin
      busy = we && (wa != 0);
      if (req && dbg_st == 1 && (!dwe || !busy)) begin
        e.due = ncyc + 1;
        e.is_rd = !dwe;
        e.rdata = mread(da, we, wa, wd);
        q.push_back(e);
        dbg_st = 2;
        if (dwe && da != 0 && int'(da) < NR) mregs[da] = dwd;
      end
      if (busy && int'(wa) < NR) mregs[wa] = wd;
    end
    @(negedge clk);
  endtask

  initial begin
    logic          r_req, r_dwe;
    logic [AW-1:0] r_da, wa, a1, a2;
    logic [31:0]   r_dwd, wd;
    logic          we;
    int            gap, hold, wait_cnt;

    rst_n = 1'b0;
    rd_we_i = 0; rd_addr_i = 0; rd_data_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
    dbg_req_i = 0; dbg_we_i = 0; dbg_addr_i = 0; dbg_wdata_i = 0;
    for (int i = 0; i < NR; i++) mregs[i] = 32'h0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ack_after_reset", {31'h0, dbg_ack_o}, 32'h0);
    chk("rdata_after_reset", dbg_rdata_o, 32'h0);

    for (int i = 0; i < NR; i++)
      cycle(0, 0, 0, AW'(i), AW'(NR - 1 - i), 0, 0, 0, 0, 1, 32'h0, 32'h0);

    // Write-first bypass, then stored value
    cycle(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h0);
    cycle(0, 0, 0, 5, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 32'h0);

    // x0 writes discarded
    cycle(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0);
    cycle(0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 32'h0, 32'hDEADBEEF);

    // Debug write blocked by writeback for 3 cycles, then served
    repeat (3) cycle(1, 3, 32'hC0FFEE00, 7, 3, 1, 1, 7, 32'hA5A5A5A5);
    cycle(0, 0, 0, 7, 3, 1, 1, 7, 32'hA5A5A5A5);
    cycle(0, 0, 0, 7, 3, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 32'hC0FFEE00);
    cycle(0, 0, 0, 7, 3, 0, 0, 0, 0);

    // Debug read racing a writeback to the same index, then held request
    cycle(1, 9, 32'h55, 9, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 9, 0, 0, 0, 0, 0, 1, 32'h55, 32'h0);
    cycle(1, 9, 32'h77, 9, 0, 1, 0, 9, 0, 1, 32'h77, 32'h0);
    repeat (4) cycle(0, 0, 0, 9, 0, 1, 0, 9, 0, 1, 32'h77, 32'h0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset asserted in the ACK cycle of a debug write
    cycle(0, 0, 0, 12, 0, 1, 1, 12, 32'hCAFEF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("ack_in_reset", {31'h0, dbg_ack_o}, 32'h0);
    chk("rdata_in_reset", dbg_rdata_o, 32'h0);
    for (int i = 0; i < NR; i++) begin
      rs1_addr_i = AW'(i); rs2_addr_i = AW'(NR - 1 - i);
      #1;
      chk("rs1_in_reset", rs1_data_o, 32'h0);
      chk("rs2_in_reset", rs2_data_o, 32'h0);
    end
    for (int i = 0; i < NR; i++) mregs[i] = 32'h0;
    dbg_st = 1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    cycle(0, 0, 0, 12, 7, 1, 1, 12, 32'hCAFEF00D, 1, 32'h0, 32'h0);
    cycle(0, 0, 0, 12, 7, 0, 0, 0, 0, 1, 32'hCAFEF00D, 32'h0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with a protocol-following debug master
    r_req = 0; r_dwe = 0; r_da = 0; r_dwd = 0; gap = 2; hold = 0; wait_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      if (r_req && dbg_st == 2) begin
        if (hold == 0) begin r_req = 0; gap = 2 + int'($urandom_range(0, 3)); end
        else hold--;
      end else if (r_req) begin
        wait_cnt++;
        if (wait_cnt > 64) begin
          nvec++; nfail++;
          $display("FAIL dbg_timeout: got no acceptance in 64 cycles, want acceptance");
          r_req = 0; gap = 4;
        end
      end else if (gap > 0) begin
        gap--;
      end else if ($urandom_range(0, 3) == 0) begin
        r_req = 1; r_dwe = 1'($urandom); r_da = AW'($urandom);
        r_dwd = $urandom; hold = int'($urandom_range(0, 4)); wait_cnt = 0;
      end
      we = 1'($urandom);
      wa = AW'($urandom);
      wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      a2 = ($urandom_range(0, 2) == 0) ? r_da : AW'($urandom);
      cycle(we, wa, wd, a1, a2, r_req, r_dwe, r_da, r_dwd);
    end
    repeat (6) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
